sub_16bit_serial: RTL and testbench

Bit-serial 16-bit subtractor computing A − B, least significant bit first, through a single full-subtractor cell and a borrow flip-flop. It is the subtract-direction counterpart of the datapath's 16-bit adder and serves the ALU for subtract and compare operations where area matters more than latency. Operation is started by a one-cycle `start` request. Completion is reported by a one-cycle `done` pulse with the difference and flags held stable.

---
 rtl/sub_16bit_serial.sv | 91 +++++++++
 tb/tb_sub_16bit_serial.sv | 113 +++++++++++
 2 files changed

// File: rtl/sub_16bit_serial.sv
// sub_16bit_serial: bit-serial 16-bit subtractor (A - B, LSB first) with borrow, overflow and zero flags
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   start            request, accepted only while not busy
//   A, B             minuend / subtrahend, captured on the accepting edge
//   busy, done       operation in progress / one-cycle result-posted pulse
//   result           A - B mod 2^16, held between operations
//   borrow_out       1 iff A < B unsigned
//   overflow         signed overflow of A - B
//   zero             1 iff result == 0
module sub_16bit_serial (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] A,
    input  logic [15:0] B,
    output logic        busy,
    output logic        done,
    output logic [15:0] result,
    output logic        borrow_out,
    output logic        overflow,
    output logic        zero
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t state, next;
    logic [15:0] a_sh, b_sh, r_sh, r_fin;
    logic [3:0] cnt;
    logic br, br_next, d, a15, b15, accept, last;
    always_comb begin
        d       = a_sh[0] ^ b_sh[0] ^ br;
        br_next = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & br);
        r_fin   = {d, r_sh[15:1]};
        accept  = (state != SHIFT) && start;
        last    = (state == SHIFT) && (cnt == 4'd15);
        next    = state;
        case (state)
            IDLE:    next = start ? SHIFT : IDLE;
            SHIFT:   next = last ? DONE : SHIFT;
            DONE:    next = start ? SHIFT : IDLE;
            default: next = IDLE;
        endcase
    end
    // busy/done are flops loaded from the next state, so they never see start combinationally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= next;
            busy  <= (next == SHIFT);
            done  <= (next == DONE);
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh       <= '0;
            b_sh       <= '0;
            r_sh       <= '0;
            cnt        <= '0;
            br         <= 1'b0;
            a15        <= 1'b0;
            b15        <= 1'b0;
            result     <= '0;
            borrow_out <= 1'b0;
            overflow   <= 1'b0;
            zero       <= 1'b1;
        end else if (accept) begin
            a_sh <= A;
            b_sh <= B;
            r_sh <= '0;
            cnt  <= '0;
            br   <= 1'b0;
            a15  <= A[15];
            b15  <= B[15];
        end else if (state == SHIFT) begin
            a_sh <= a_sh >> 1;
            b_sh <= b_sh >> 1;
            r_sh <= r_fin;
            br   <= br_next;
            cnt  <= cnt + 4'd1;
            // sign bits are kept aside because a_sh/b_sh are consumed by the shift
            if (last) begin
                result     <= r_fin;
                borrow_out <= br_next;
                overflow   <= (a15 != b15) && (r_fin[15] != a15);
                zero       <= (r_fin == 16'h0000);
            end
        end
    end
endmodule

// File: tb/tb_sub_16bit_serial.sv
// tb_sub_16bit_serial: self-checking bench for sub_16bit_serial against an arithmetic reference
module tb_sub_16bit_serial;
    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
    logic [15:0] A = '0, B = '0;
    logic busy, done, borrow_out, overflow, zero;
    logic [15:0] result;
    int checks = 0, errors = 0;
    logic [15:0] p_res = 16'h0000;
    logic p_bo = 1'b0, p_ov = 1'b0, p_z = 1'b1;

    sub_16bit_serial dut (
        .clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B),
        .busy(busy), .done(done), .result(result),
        .borrow_out(borrow_out), .overflow(overflow), .zero(zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_held(input string tag);
        chk({tag, "_result"}, {16'h0, result}, {16'h0, p_res});
        chk({tag, "_flags"}, {29'h0, borrow_out, overflow, zero}, {29'h0, p_bo, p_ov, p_z});
    endtask

    // Starts at a negedge, drives a request, and returns at the negedge of the done cycle
    // (or just after releasing reset when rst_at is hit).
    task automatic op(input logic [15:0] a, input logic [15:0] b, input int pulse_at, input int rst_at);
        int unsigned diff;
        logic [15:0] er;
        logic ebo, eov;
        diff = (32'(a) + 32'h10000 - 32'(b)) % 32'h10000;
        er   = diff[15:0];
        ebo  = a < b;
        eov  = ($signed(a) - $signed(b) > 32767) || ($signed(a) - $signed(b) < -32768);
        A = a; B = b; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0; A = 16'($urandom); B = 16'($urandom);
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            chk("busy_shift", {31'h0, busy}, 32'h1);
            chk("done_shift", {31'h0, done}, 32'h0);
            chk_held("hold");
            if (i == pulse_at) begin
                start = 1'b1; A = 16'hFFFF; B = 16'h0000;
                @(posedge clk);
                #1 start = 1'b0;
            end
            if (i == rst_at) begin
                rst_n = 1'b0;
                #1;
                chk("rst_busy", {31'h0, busy}, 32'h0);
                chk("rst_done", {31'h0, done}, 32'h0);
                chk("rst_result", {16'h0, result}, 32'h0);
                chk("rst_flags", {29'h0, borrow_out, overflow, zero}, 32'h1);
                p_res = 16'h0; p_bo = 1'b0; p_ov = 1'b0; p_z = 1'b1;
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
        end
        @(negedge clk);
        chk("done_pulse", {31'h0, done}, 32'h1);
        chk("busy_done", {31'h0, busy}, 32'h0);
        chk("result", {16'h0, result}, {16'h0, er});
        chk("borrow", {31'h0, borrow_out}, {31'h0, ebo});
        chk("overflow", {31'h0, overflow}, {31'h0, eov});
        chk("zero", {31'h0, zero}, {31'h0, er == 16'h0});
        p_res = er; p_bo = ebo; p_ov = eov; p_z = (er == 16'h0);
    endtask

    task automatic idle(input int n);
        start = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("idle_done", {31'h0, done}, 32'h0);
            chk("idle_busy", {31'h0, busy}, 32'h0);
            chk_held("idle");
        end
    endtask

    initial begin
        #12;
        chk("reset_busy", {31'h0, busy}, 32'h0);
        chk("reset_done", {31'h0, done}, 32'h0);
        chk_held("reset");
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);
        op(16'h1234, 16'h0034, -1, -1); idle(1);
        op(16'h0000, 16'h0001, -1, -1); idle(1);
        op(16'h8000, 16'h0001, -1, -1); idle(1);
        op(16'h7FFF, 16'hFFFF, -1, -1); idle(1);
        op(16'h5555, 16'h5555, -1, -1);
        op(16'h0003, 16'h0005, -1, -1); idle(1);
        op(16'h00FF, 16'h000F, 5, -1); idle(3);
        op(16'hABCD, 16'h1111, -1, 8); idle(20);
        op(16'h0100, 16'h0001, -1, -1); idle(1);
        for (int k = 0; k < 40; k++) begin
            op(16'($urandom), 16'($urandom), -1, -1);
            if ($urandom_range(0, 1) == 0) idle($urandom_range(1, 3));
        end
        idle(1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
